// File: rtl/hex_display_scanner.sv
// Multiplexed seven-segment driver: scans DIGITS hex nibbles of one of CHANNELS words,
// with manual/auto/freeze channel selection, per-frame snapshots and leading-zero blanking.
module hex_display_scanner #(
  parameter int DIGITS        = 4,
  parameter int CHANNELS      = 2,
  parameter int REFRESH_DIV   = 100000,
  parameter int ROTATE_FRAMES = 500
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [CHANNELS*4*DIGITS-1:0]  Values,
  input  logic [1:0]                    Mode,
  input  logic                          NextChan,
  input  logic                          BlankLZ,
  output logic [6:0]                    Out7,
  output logic [DIGITS-1:0]             EnOut,
  output logic [$clog2(CHANNELS)-1:0]   Chan,
  output logic                          FrameOut
);

  localparam int W   = 4 * DIGITS;
  localparam int CW  = $clog2(CHANNELS);
  localparam int RCW = $clog2(REFRESH_DIV);
  localparam int DW  = $clog2(DIGITS);
  localparam int FCW = $clog2(ROTATE_FRAMES + 1);
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;

  logic [RCW-1:0] rc_reg;
  logic [DW-1:0]  d_reg, d_next;
  logic           first_reg;
  logic [CW-1:0]  chan_reg, chan_next, chan_inc;
  logic [FCW-1:0] fc_reg, fc_next;
  logic [W-1:0]   snap_reg, snap_next;
  logic           prev_reg;
  logic [6:0]     out7_reg, out7_next;
  logic [DIGITS-1:0] en_reg;
  logic           frame_reg;
  logic           tick, frame_start, blank;
  logic [DW-1:0]  hi_digit;
  logic [3:0]     nib [DIGITS];

  assign tick = (rc_reg == RCW'(REFRESH_DIV - 1));

  // The first tick after reset always lands on digit 0 so the first frame starts cleanly.
  always_comb begin
    d_next = d_reg;
    if (tick) begin
      if (first_reg || d_reg == DW'(DIGITS - 1))
        d_next = '0;
      else
        d_next = d_reg + DW'(1);
    end
  end

  assign frame_start = tick && (d_next == '0);
  assign chan_inc    = (chan_reg == CW'(CHANNELS - 1)) ? '0 : chan_reg + CW'(1);

  always_comb begin
    snap_next = snap_reg;
    if (frame_start && Mode != MODE_FREEZE)
      snap_next = Values[chan_reg*W +: W];
  end

  always_comb begin
    chan_next = chan_reg;
    fc_next   = '0;
    case (Mode)
      MODE_AUTO: begin
        fc_next = fc_reg;
        if (frame_start) begin
          if (fc_reg == FCW'(ROTATE_FRAMES - 1)) begin
            fc_next   = '0;
            chan_next = chan_inc;
          end else begin
            fc_next = fc_reg + FCW'(1);
          end
        end
      end
      MODE_FREEZE: ;
      default: if (NextChan && !prev_reg) chan_next = chan_inc;
    endcase
  end

  // Nibbles of the snapshot as it will be after this edge, so a frame start shows fresh data.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign nib[gi] = snap_next[gi*4 +: 4];
  end

  always_comb begin
    hi_digit = '0;
    for (int i = 0; i < DIGITS; i++)
      if (nib[i] != 4'h0) hi_digit = DW'(i);
  end

  assign blank = BlankLZ && (d_next > hi_digit);

  always_comb begin
    out7_next = 7'h7F;
    if (!blank) begin
      case (nib[d_next])
        4'h0: out7_next = 7'h01;
        4'h1: out7_next = 7'h4F;
        4'h2: out7_next = 7'h12;
        4'h3: out7_next = 7'h06;
        4'h4: out7_next = 7'h4C;
        4'h5: out7_next = 7'h24;
        4'h6: out7_next = 7'h20;
        4'h7: out7_next = 7'h0F;
        4'h8: out7_next = 7'h00;
        4'h9: out7_next = 7'h04;
        4'hA: out7_next = 7'h08;
        4'hB: out7_next = 7'h60;
        4'hC: out7_next = 7'h31;
        4'hD: out7_next = 7'h42;
        4'hE: out7_next = 7'h30;
        default: out7_next = 7'h38;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rc_reg    <= '0;
      d_reg     <= '0;
      first_reg <= 1'b1;
      chan_reg  <= '0;
      fc_reg    <= '0;
      snap_reg  <= '0;
      prev_reg  <= 1'b0;
      out7_reg  <= 7'h7F;
      en_reg    <= '1;
      frame_reg <= 1'b0;
    end else begin
      rc_reg    <= tick ? '0 : rc_reg + RCW'(1);
      d_reg     <= d_next;
      if (tick) first_reg <= 1'b0;
      chan_reg  <= chan_next;
      fc_reg    <= fc_next;
      snap_reg  <= snap_next;
      prev_reg  <= NextChan;
      frame_reg <= frame_start;
      if (tick) begin
        out7_reg <= out7_next;
        en_reg   <= ~(DIGITS'(1) << d_next);
      end
    end
  end

  assign Out7     = out7_reg;
  assign EnOut    = en_reg;
  assign Chan     = chan_reg;
  assign FrameOut = frame_reg;

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Parametrised multiplexed seven-segment display driver, the next generation of the board's 4-digit debug display. It time-multiplexes DIGITS hex digits of one of CHANNELS input words onto shared segment lines. Channel selection is manual, auto-rotating or frozen, with tear-free per-frame snapshots and optional leading-zero blanking. It sits at the top level beside the fetch unit, showing PC, instruction and other debug words on the board display.

## Interface
- DIGITS, 4: number of hex digits per channel (≥2); channel word width W = 4*DIGITS.
- CHANNELS, 2: number of selectable input words (≥2); CW = $clog2(CHANNELS).
- REFRESH_DIV, 100000: Clk cycles per digit slot (≥2).
- ROTATE_FRAMES, 500: frames per channel in auto mode (≥1).

- Clk  input  1  system clock; all state on rising edge.
- Reset  input  1  synchronous, active-low reset.
- Values  input  CHANNELS*W  channel c occupies bits [c*W +: W].
- Mode  input  2  00 manual, 01 auto-rotate, 10 freeze, 11 treated as 00.
- NextChan  input  1  level input (synchronous, pre-debounced); a rising edge advances the channel in manual mode.
- BlankLZ  input  1  1 = blank leading zero digits.
- Out7  output  7  segments {a,b,c,d,e,f,g}, active-low, registered.
- EnOut  output  DIGITS  digit enables, active-low, registered; bit 0 = least-significant nibble.
- Chan  output  CW  currently selected channel.
- FrameOut  output  1  one-cycle pulse when a new snapshot is loaded.

## Operation
- Refresh counter rc counts 0..REFRESH_DIV-1 and wraps. tick = (rc == REFRESH_DIV-1).
- Digit index d advances on tick, DIGITS-1 wraps to 0. A frame starts on every tick that moves d to 0, and on the first tick after reset.
- Frame start: if Mode != 10, snap <= Values[Chan*W +: W], using Chan's value before any same-edge update. FrameOut = 1 for that cycle. In freeze mode snap is held, but FrameOut still pulses.
- Manual (00/11): edge detector holds prev NextChan. When NextChan=1 and prev=0, Chan <= (Chan==CHANNELS-1) ? 0 : Chan+1. A new channel appears from the next frame start.
- Auto (01): frame counter fc increments per frame start. When fc reaches ROTATE_FRAMES-1 at a frame start, fc <= 0 and Chan advances with wrap. NextChan is ignored. fc clears whenever Mode != 01.
- Freeze (10): Chan and snap hold. NextChan is ignored.
- prev NextChan tracks the input in all modes, so a level held through a mode change does not produce a spurious edge.
- Decode of nibble n = snap[4d +: 4]: standard hex glyphs 0-9, A, b, C, d, E, F; active-low.
- Blanking: with BlankLZ=1, digit d is blanked when d > index of the highest nonzero nibble of snap. Digit 0 is never blanked, so zero shows as "0". A blanked slot drives Out7 = 7'h7F, and its EnOut bit is still asserted.
- On each tick, EnOut <= ~(1 << d_next) and Out7 <= glyph of the nibble at d_next from the snapshot as updated on that same edge.

## Timing
- Reset (Reset=0 at an edge): rc=0, d=0, Chan=0, fc=0, snap=0, prev=0, Out7=7'h7F, EnOut=all ones (display dark), FrameOut=0.
- The first tick after reset occurs REFRESH_DIV edges after reset release. It is a frame start, lights digit 0 with the fresh snapshot, and pulses FrameOut.
- Out7/EnOut change only on tick edges and hold for exactly REFRESH_DIV cycles. Exactly one EnOut bit is low after the first tick.
- Frame period = DIGITS*REFRESH_DIV cycles. The auto channel period is ROTATE_FRAMES frames.
- Chan updates the edge after the NextChan rising edge (manual) or on the frame-start edge (auto).
- Values changes mid-frame never appear until the next frame start (no tearing).
- Reset mid-frame returns all state to reset values on that edge and the display goes dark.
- Mode changes take effect at the next edge. A change to freeze at a frame-start edge is evaluated with the Mode sampled on that edge.

## Test plan
Setup for all scenarios: DIGITS=4, CHANNELS=2, REFRESH_DIV=4, ROTATE_FRAMES=2.

- Reset then release, Values={16'hBEEF,16'h1234}, Mode=00 -> dark for 4 cycles. Then EnOut=4'b1110 with Out7=glyph 4, then 1101/3, 1011/2, 0111/1, every 4 cycles. FrameOut pulses at cycle 4 and cycle 20.
- Manual: pulse NextChan mid-frame -> Chan=1 the next edge. Digits continue showing 1234 until the next frame start, then F,E,E,b. Holding NextChan high advances Chan only once.
- Auto: Mode=01 -> Chan toggles every 2 frames (32 cycles). NextChan is ignored.
- Freeze: Mode=10 after showing 1234, then change Values to 16'h5678 -> display stays 1234 and Chan holds. Return to Mode=00 -> 5678 appears at the next frame start.
- Blanking: BlankLZ=1, channel value 16'h0040 -> digits 3 and 2 show Out7=7'h7F, digit 1 shows 4, digit 0 shows 0. Value 16'h0000 -> only digit 0 shows 0.
- Reset asserted mid-frame -> outputs return to Out7=7'h7F and EnOut=4'hF at that edge, and Chan=0.
